// File: rtl/iomem_initiator.sv
// iomem_initiator: single-outstanding command-to-iomem bus initiator with registered request and response.
// Define IOMEM_INITIATOR_TIMEOUT_EN to add the TIMEOUT_CYCLES abort path; otherwise BUS waits forever.
module iomem_initiator #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        iomem_valid,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    output logic [3:0]  iomem_wstrb,
    input  logic        iomem_ready,
    input  logic [31:0] iomem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        timeout;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("iomem_initiator: TIMEOUT_CYCLES must be within 2..65535");
    end

`ifdef IOMEM_INITIATOR_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        err_q;

    assign timeout   = cnt_q == 16'(TIMEOUT_CYCLES - 1);
    assign rsp_error = err_q;

    // Counter restarts every time BUS is entered; err_q is frozen once BUS is left.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= state_q != BUS ? 16'd0 : (cnt_q == 16'hFFFF ? cnt_q : cnt_q + 16'd1);
            err_q <= state_q == BUS ? (!iomem_ready && timeout) : err_q;
        end
    end
`else
    assign timeout   = 1'b0;
    assign rsp_error = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                write_d = cmd_write;
                addr_d  = cmd_addr;
                wdata_d = cmd_wdata;
                wstrb_d = cmd_write ? cmd_wstrb : 4'b0000;
                state_d = BUS;
            end
            // A ready in the timeout cycle takes priority over the abort.
            BUS: if (iomem_ready || timeout) begin
                rdata_d = (iomem_ready && !write_q) ? iomem_rdata : 32'd0;
                state_d = RESP;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
        end
    end

    assign cmd_ready   = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign iomem_valid = state_q == BUS;
    assign rsp_valid   = state_q == RESP;
    assign iomem_addr  = addr_q;
    assign iomem_wdata = wdata_q;
    assign iomem_wstrb = wstrb_q;
    assign rsp_rdata   = rdata_q;
endmodule

// File: tb/tb_iomem_initiator.sv
// tb_iomem_initiator: directed cycle-accurate checks of iomem_initiator with TIMEOUT_CYCLES=8.
module tb_iomem_initiator;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        iomem_valid, iomem_ready = 1'b0;
    logic [31:0] iomem_addr, iomem_wdata, iomem_rdata = '0;
    logic [3:0]  iomem_wstrb;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_error, busy;
    logic [31:0] rsp_rdata;
    int          n_checks = 0, n_fail = 0;

    iomem_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .iomem_valid(iomem_valid), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .iomem_wstrb(iomem_wstrb), .iomem_ready(iomem_ready), .iomem_rdata(iomem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int k, r;
        repeat (2) tick();
        reset = 1'b0;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_iomem_valid", iomem_valid, 0);
        check("rst_addr", iomem_addr, 0);
        check("rst_wdata", iomem_wdata, 0);
        check("rst_wstrb", iomem_wstrb, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_busy", busy, 0);

        // Read, zero wait state
        iomem_ready = 1'b1;
        iomem_rdata = 32'hA5A5_0001;
        send(1'b0, 32'h0300_0000, 32'hFFFF_FFFF, 4'hF);
        check("rd_valid", iomem_valid, 1);
        check("rd_addr", iomem_addr, 32'h0300_0000);
        check("rd_wstrb", iomem_wstrb, 0);
        check("rd_cmd_ready", cmd_ready, 0);
        check("rd_busy", busy, 1);
        tick();
        iomem_ready = 1'b0;
        check("rd_valid_drop", iomem_valid, 0);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
        check("rd_rsp_error", rsp_error, 0);
        take_rsp();
        check("rd_after_rsp_valid", rsp_valid, 0);
        check("rd_after_cmd_ready", cmd_ready, 1);

        // Write, 3 wait states
        iomem_rdata = 32'hDEAD_BEEF;
        send(1'b1, 32'h0400_0004, 32'h1234_5678, 4'b0011);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wr_valid%0d", i), iomem_valid, 1);
            check($sformatf("wr_addr%0d", i), iomem_addr, 32'h0400_0004);
            check($sformatf("wr_wdata%0d", i), iomem_wdata, 32'h1234_5678);
            check($sformatf("wr_wstrb%0d", i), iomem_wstrb, 4'b0011);
            iomem_ready = i == 3;
            tick();
        end
        iomem_ready = 1'b0;
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_rsp_error", rsp_error, 0);

        // Backpressure with a new command waiting
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0500_0000;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_rsp_valid%0d", i), rsp_valid, 1);
            check($sformatf("bp_rsp_rdata%0d", i), rsp_rdata, 0);
            check($sformatf("bp_cmd_ready%0d", i), cmd_ready, 0);
            check($sformatf("bp_iomem_valid%0d", i), iomem_valid, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_r1_cmd_ready", cmd_ready, 1);
        check("bp_r1_iomem_valid", iomem_valid, 0);
        check("bp_r1_rsp_valid", rsp_valid, 0);
        tick();
        cmd_valid = 1'b0;
        check("bp_r2_iomem_valid", iomem_valid, 1);
        check("bp_r2_addr", iomem_addr, 32'h0500_0000);
        check("bp_r2_wstrb", iomem_wstrb, 0);
        iomem_ready = 1'b1;
        iomem_rdata = 32'h1111_2222;
        tick();
        iomem_ready = 1'b0;
        check("bp_rsp_rdata", rsp_rdata, 32'h1111_2222);
        take_rsp();

        // Reset during a wait state
        send(1'b1, 32'h0600_0000, 32'h5555_AAAA, 4'hF);
        tick();
        check("rst_mid_busy_before", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_iomem_valid", iomem_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_addr", iomem_addr, 0);
        tick();
        check("rst_mid_rsp_valid2", rsp_valid, 0);
        iomem_ready = 1'b1;
        iomem_rdata = 32'h0BAD_F00D;
        send(1'b0, 32'h0700_0000, 32'h0, 4'h0);
        check("rst_next_addr", iomem_addr, 32'h0700_0000);
        tick();
        iomem_ready = 1'b0;
        check("rst_next_rsp_valid", rsp_valid, 1);
        check("rst_next_rdata", rsp_rdata, 32'h0BAD_F00D);
        take_rsp();

`ifdef IOMEM_INITIATOR_TIMEOUT_EN
        iomem_rdata = 32'hCAFE_0000;
        send(1'b0, 32'h0800_0000, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("to_valid%0d", i), iomem_valid, 1);
            check($sformatf("to_rsp_valid%0d", i), rsp_valid, 0);
            tick();
        end
        check("to_valid_drop", iomem_valid, 0);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_error", rsp_error, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        take_rsp();
        send(1'b0, 32'h0800_0004, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                iomem_ready = 1'b1;
                iomem_rdata = 32'h1357_2468;
            end
            tick();
        end
        iomem_ready = 1'b0;
        check("to_late_rsp_valid", rsp_valid, 1);
        check("to_late_rsp_error", rsp_error, 0);
        check("to_late_rsp_rdata", rsp_rdata, 32'h1357_2468);
        take_rsp();
`else
        send(1'b0, 32'h0800_0000, 32'h0, 4'h0);
        repeat (20) tick();
        check("nto_still_valid", iomem_valid, 1);
        check("nto_no_rsp", rsp_valid, 0);
        check("nto_error", rsp_error, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("nto_reset_exit", busy, 0);
`endif

        // Back-to-back zero-wait reads, responder echoes addr ^ mask
        iomem_ready = 1'b1;
        rsp_ready   = 1'b1;
        k = 0;
        r = 0;
        for (int c = 0; c < 12; c++) begin
            check($sformatf("b2b_valid_c%0d", c), iomem_valid, (c % 3) == 1);
            iomem_rdata = iomem_addr ^ 32'hFFFF_0000;
            if (rsp_valid) begin
                check($sformatf("b2b_rsp%0d", r), rsp_rdata, (32'h0900_0000 + 32'(r * 4)) ^ 32'hFFFF_0000);
                r++;
            end
            if (cmd_ready && k < 4) begin
                cmd_valid = 1'b1;
                cmd_write = 1'b0;
                cmd_addr  = 32'h0900_0000 + 32'(k * 4);
                k++;
            end else if (cmd_ready) begin
                cmd_valid = 1'b0;
            end
            tick();
        end
        cmd_valid   = 1'b0;
        iomem_ready = 1'b0;
        rsp_ready   = 1'b0;
        check("b2b_rsp_count", 32'(r), 4);
        check("b2b_last_addr", iomem_addr, 32'h0900_000C);
        check("b2b_idle", cmd_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
